// File: rtl/vga_bitplane_fifo.sv
// Prefetch FIFO between a word-addressed memory bus and the VGA bitplane shifter.
// Fetches frame words ahead of the display and discards in-flight data across vsync flushes.
module vga_bitplane_fifo #(
    parameter int fifo_addr_bits  = 4,
    parameter int words_per_frame = 38400
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [29:0] addr_base,
    input  logic        vga_vsync,
    output logic        addr_strobe,
    output logic [29:0] addr,
    input  logic        data_ready,
    input  logic [31:0] data_in,
    input  logic        fetch_next,
    output logic [7:0]  red_byte,
    output logic [7:0]  green_byte,
    output logic [7:0]  blue_byte,
    output logic [7:0]  bright_byte,
    output logic        underflow
);

    localparam int unsigned             DEPTH = 1 << fifo_addr_bits;
    localparam logic [fifo_addr_bits:0] FULL  = (fifo_addr_bits + 1)'(DEPTH);
    localparam logic [29:0]             WPF   = 30'(words_per_frame);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               mem_q [DEPTH];
    logic [fifo_addr_bits-1:0] wptr_q, wptr_d;
    logic [fifo_addr_bits-1:0] rptr_q, rptr_d;
    logic [fifo_addr_bits:0]   count_q, count_d;
    logic [29:0]               faddr_q, faddr_d;
    logic [29:0]               addr_q, addr_d;
    logic [29:0]               base_q, base_d;
    logic                      uf_q, uf_d;
    logic                      wr_en;
    logic                      pop;
    logic [29:0]               faddr_inc;
    logic [31:0]               head;

    // Bus FSM: the request address is captured at issue so a flush cannot disturb it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (vga_vsync && (count_q < FULL)) begin
                    state_d = REQ;
                    addr_d  = faddr_q;
                end
            end
            REQ: begin
                if (data_ready) begin
                    state_d = IDLE;
                    wr_en   = vga_vsync;
                end else if (!vga_vsync) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (data_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_strobe = (state_q != IDLE);
    assign addr        = addr_q;

    always_comb begin
        pop       = vga_vsync && fetch_next && (count_q != '0);
        faddr_inc = faddr_q + 30'd1;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        faddr_d   = faddr_q;
        base_d    = base_q;
        uf_d      = uf_q | (vga_vsync && fetch_next && (count_q == '0));
        if (wr_en) begin
            wptr_d  = wptr_q + 1'b1;
            faddr_d = (faddr_inc == base_q + WPF) ? base_q : faddr_inc;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (!vga_vsync) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            faddr_d = addr_base;
            base_d  = addr_base;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            faddr_q <= addr_base;
            base_q  <= addr_base;
            addr_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            faddr_q <= faddr_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            uf_q    <= uf_d;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset && wr_en) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign head        = mem_q[rptr_q];
    assign red_byte    = (count_q != '0) ? head[7:0]   : '0;
    assign green_byte  = (count_q != '0) ? head[15:8]  : '0;
    assign blue_byte   = (count_q != '0) ? head[23:16] : '0;
    assign bright_byte = (count_q != '0) ? head[31:24] : '0;
    assign underflow   = uf_q;

endmodule
